dram_test_seq: RTL and testbench

Parametrised DRAM pattern tester, successor to the single-pass address-pattern tester. It drives the DRAM controller's request, write-data and read-data FIFOs through a start-triggered, multi-pass write-then-verify sequence. The sequence supports four selectable data patterns and per-pass bit inversion, keeps up to MAX_OUTSTANDING reads in flight, issues one request per cycle, and reports errors with a saturating count and first-failure capture.

---
 rtl/dram_test_seq_pkg.sv | 21 ++
 rtl/dram_test_pattern.sv | 37 +++
 rtl/dram_test_seq.sv | 195 +++++++++++++++++++
 tb/tb_dram_test_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_test_seq_pkg.sv
// Shared types for the DRAM pattern tester.
// State encodings, pattern modes and request-word layout.
package dram_test_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_ADDR    = 2'd0;
  localparam logic [1:0] MODE_NADDR   = 2'd1;
  localparam logic [1:0] MODE_ONEHOT  = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  localparam int REQ_WR_BIT   = 0;
  localparam int REQ_ADDR_LSB = 1;

endpackage

// File: rtl/dram_test_pattern.sv
// Combinational test-pattern generator.
// Odd passes invert every bit of the base pattern.
module dram_test_pattern
  import dram_test_seq_pkg::*;
#(
  parameter int PAGE_LEN = 32,
  parameter int ADDR_W   = 1
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                pass_odd,
  input  logic [1:0]          mode,
  output logic [PAGE_LEN-1:0] pattern
);

  localparam int SW = $clog2(PAGE_LEN);

  logic [ADDR_W-1:0]   addr_n;
  logic [SW-1:0]       sh;
  logic [PAGE_LEN-1:0] base;

  assign addr_n = ~addr;
  assign sh     = SW'(addr);

  always_comb begin
    base = '0;
    unique case (mode)
      MODE_ADDR:    base = PAGE_LEN'(addr);
      MODE_NADDR:   base = PAGE_LEN'(addr_n);
      MODE_ONEHOT:  base = PAGE_LEN'(1) << sh;
      MODE_CHECKER: base = addr[0] ? {(PAGE_LEN/2){2'b10}}
                                   : {(PAGE_LEN/2){2'b01}};
      default:      base = '0;
    endcase
    pattern = base ^ {PAGE_LEN{pass_odd}};
  end

endmodule

// File: rtl/dram_test_seq.sv
// Multi-pass write-then-verify DRAM pattern tester.
// Drives request/write-data FIFOs and checks show-ahead read data.
module dram_test_seq
  import dram_test_seq_pkg::*;
#(
  parameter int LOG_DRAM_SIZE   = 6,
  parameter int PAGE_LEN        = 32,
  parameter int LOG_ADDR_SIZE   = LOG_DRAM_SIZE - $clog2(PAGE_LEN),
  parameter int LOG_REQ_SIZE    = 1 + LOG_ADDR_SIZE,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [3:0]               passes,
  output logic                     frq_write_en,
  output logic [LOG_REQ_SIZE-1:0]  frq_write_data,
  input  logic                     frq_full,
  output logic                     fout_write_en,
  output logic [PAGE_LEN-1:0]      fout_write_data,
  input  logic                     fout_full,
  output logic                     fin_read_en,
  input  logic [PAGE_LEN-1:0]      fin_read_data,
  input  logic                     fin_empty,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic [LOG_ADDR_SIZE-1:0] first_err_addr
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);

  typedef logic [LOG_ADDR_SIZE-1:0] addr_t;
  localparam addr_t ADDR_LAST = '1;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [3:0]          last_q, last_d;
  logic [3:0]          pass_q, pass_d;
  addr_t               wr_q, wr_d;
  addr_t               rd_q, rd_d;
  addr_t               cmp_q, cmp_d;
  addr_t               ferr_q, ferr_d;
  logic                iss_q, iss_d;
  logic [OW-1:0]       out_q, out_d;
  logic                err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                frq_en_d, fout_en_d;
  logic [LOG_REQ_SIZE-1:0] frq_dat_d;
  logic [PAGE_LEN-1:0] fout_dat_d;
  logic [PAGE_LEN-1:0] wr_pat, cmp_pat;
  logic                rd_go;

  dram_test_pattern #(.PAGE_LEN(PAGE_LEN), .ADDR_W(LOG_ADDR_SIZE)) u_wr_pat (
    .addr(wr_q), .pass_odd(pass_q[0]), .mode(mode_q), .pattern(wr_pat)
  );

  dram_test_pattern #(.PAGE_LEN(PAGE_LEN), .ADDR_W(LOG_ADDR_SIZE)) u_cmp_pat (
    .addr(cmp_q), .pass_odd(pass_q[0]), .mode(mode_q), .pattern(cmp_pat)
  );

  assign fin_read_en    = (state_q == S_READ) && !fin_empty && (out_q != '0);
  assign busy           = state_q inside {S_WRITE, S_READ, S_NEXT};
  assign done           = state_q == S_DONE;
  assign error          = err_q;
  assign err_count      = cnt_q;
  assign first_err_addr = ferr_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    last_d     = last_q;
    pass_d     = pass_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cmp_d      = cmp_q;
    ferr_d     = ferr_q;
    iss_d      = iss_q;
    out_d      = out_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    frq_en_d   = 1'b0;
    fout_en_d  = 1'b0;
    frq_dat_d  = frq_write_data;
    fout_dat_d = fout_write_data;
    rd_go      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          mode_d  = mode;
          last_d  = (passes == 4'd0) ? 4'd0 : passes - 4'd1;
          pass_d  = '0;
          wr_d    = '0;
          rd_d    = '0;
          cmp_d   = '0;
          ferr_d  = '0;
          iss_d   = 1'b0;
          out_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_WRITE: begin
        if (!frq_full && !fout_full) begin
          frq_en_d  = 1'b1;
          fout_en_d = 1'b1;
          frq_dat_d = '0;
          frq_dat_d[REQ_WR_BIT] = 1'b1;
          frq_dat_d[REQ_ADDR_LSB +: LOG_ADDR_SIZE] = wr_q;
          fout_dat_d = wr_pat;
          wr_d = wr_q + 1'b1;
          if (wr_q == ADDR_LAST) state_d = S_READ;
        end
      end
      S_READ: begin
        rd_go = !frq_full && (out_q < OMAX) && !iss_q;
        if (rd_go) begin
          frq_en_d  = 1'b1;
          frq_dat_d = '0;
          frq_dat_d[REQ_ADDR_LSB +: LOG_ADDR_SIZE] = rd_q;
          rd_d = rd_q + 1'b1;
          if (rd_q == ADDR_LAST) iss_d = 1'b1;
        end
        if (fin_read_en) begin
          cmp_d = cmp_q + 1'b1;
          if (fin_read_data != cmp_pat) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!err_q) ferr_d = cmp_q;
          end
          if (cmp_q == ADDR_LAST)
            state_d = (pass_q == last_q) ? S_DONE : S_NEXT;
        end
        if (rd_go && !fin_read_en)
          out_d = out_q + 1'b1;
        else if (!rd_go && fin_read_en)
          out_d = out_q - 1'b1;
      end
      S_NEXT: begin
        pass_d  = pass_q + 4'd1;
        wr_d    = '0;
        rd_d    = '0;
        cmp_d   = '0;
        iss_d   = 1'b0;
        out_d   = '0;
        state_d = S_WRITE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      mode_q          <= '0;
      last_q          <= '0;
      pass_q          <= '0;
      wr_q            <= '0;
      rd_q            <= '0;
      cmp_q           <= '0;
      ferr_q          <= '0;
      iss_q           <= 1'b0;
      out_q           <= '0;
      err_q           <= 1'b0;
      cnt_q           <= '0;
      frq_write_en    <= 1'b0;
      fout_write_en   <= 1'b0;
      frq_write_data  <= '0;
      fout_write_data <= '0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      last_q          <= last_d;
      pass_q          <= pass_d;
      wr_q            <= wr_d;
      rd_q            <= rd_d;
      cmp_q           <= cmp_d;
      ferr_q          <= ferr_d;
      iss_q           <= iss_d;
      out_q           <= out_d;
      err_q           <= err_d;
      cnt_q           <= cnt_d;
      frq_write_en    <= frq_en_d;
      fout_write_en   <= fout_en_d;
      frq_write_data  <= frq_dat_d;
      fout_write_data <= fout_dat_d;
    end
  end

endmodule

// File: tb/tb_dram_test_seq.sv
// Bench for dram_test_seq: two instances (default and MAX_OUTSTANDING=1,
// ERR_CNT_W=2) against a loopback memory with faults, delays and stalls.
module tb_dram_test_seq;

  localparam int AW = 1;
  localparam int RW = AW + 1;
  localparam int PL = 32;
  localparam int N  = 1 << AW;

  logic clk, rst, start;
  logic [1:0] mode;
  logic [3:0] passes;

  logic          frq_write_en    [2];
  logic [RW-1:0] frq_write_data  [2];
  logic          frq_full        [2];
  logic          fout_write_en   [2];
  logic [PL-1:0] fout_write_data [2];
  logic          fout_full       [2];
  logic          fin_read_en     [2];
  logic [PL-1:0] fin_read_data   [2];
  logic          fin_empty       [2];
  logic          busy            [2];
  logic          done            [2];
  logic          error           [2];
  logic [15:0]   err_count       [2];
  logic [AW-1:0] first_err_addr  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int MO = (g == 0) ? 4 : 1;
    localparam int EW = (g == 0) ? 16 : 2;
    logic [EW-1:0] ec;
    dram_test_seq #(.MAX_OUTSTANDING(MO), .ERR_CNT_W(EW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .passes(passes),
      .frq_write_en(frq_write_en[g]), .frq_write_data(frq_write_data[g]),
      .frq_full(frq_full[g]),
      .fout_write_en(fout_write_en[g]), .fout_write_data(fout_write_data[g]),
      .fout_full(fout_full[g]),
      .fin_read_en(fin_read_en[g]), .fin_read_data(fin_read_data[g]),
      .fin_empty(fin_empty[g]),
      .busy(busy[g]), .done(done[g]), .error(error[g]),
      .err_count(ec), .first_err_addr(first_err_addr[g])
    );
    assign err_count[g] = 16'(ec);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Environment configuration and memory model state
  int full_mode [2];
  int delay     [2];
  int fault     [2];
  logic [PL-1:0] mem [2][N];
  logic [PL-1:0] rq_data [2][64];
  int rq_rdy [2][64];
  int head [2], tail [2], k [2], pops [2], outst [2];
  int last_pop [2], last_req [2];
  int run_mode, total_reads, cyc;

  function automatic logic [PL-1:0] ref_pat(input int a, input int p,
                                            input int m);
    logic [PL-1:0] v;
    case (m)
      0:       v = PL'(a);
      1:       v = PL'((~a) & (N - 1));
      2:       v = PL'(1) << (a % PL);
      default: v = (a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
    if (p % 2 == 1) v = ~v;
    return v;
  endfunction

  function automatic void exp_res(input int i, input int m, input int np,
                                  output int cnt, output int first,
                                  output int err);
    int cap = (i == 0) ? 65535 : 3;
    int pl = (np == 0) ? 1 : np;
    logic [PL-1:0] w, r;
    cnt = 0; first = 0; err = 0;
    for (int p = 0; p < pl; p++)
      for (int a = 0; a < N; a++) begin
        w = ref_pat(a, p, m);
        r = w;
        if (fault[i] == 1 && a == 1) r = w | 32'h8;
        if (fault[i] == 2) r = '0;
        if (r != w) begin
          if (err == 0) first = a;
          err = 1;
          if (cnt < cap) cnt++;
        end
      end
  endfunction

  task automatic observe(input int i);
    int r, p, a;
    if (rst) begin
      head[i] = 0; tail[i] = 0; outst[i] = 0;
      return;
    end
    if (fin_read_en[i]) begin
      chk("pop_nonempty", 32'(fin_empty[i]), 0);
      if (head[i] != tail[i]) begin
        head[i]++;
        outst[i]--;
      end
      pops[i]++;
      if (pops[i] == total_reads) last_pop[i] = cyc;
    end
    if (frq_write_en[i] || fout_write_en[i])
      chk("fout_en", 32'(fout_write_en[i]),
          32'(frq_write_en[i] && frq_write_data[i][0]));
    if (frq_write_en[i]) begin
      r = k[i] % (2 * N);
      p = k[i] / (2 * N);
      chk("req_seq", 32'(frq_write_data[i]),
          (r < N) ? (r * 2 + 1) : ((r - N) * 2));
      if (i == 0 && full_mode[0] == 0 && r != 0)
        chk("req_gap", cyc - last_req[i], 1);
      last_req[i] = cyc;
      a = int'(frq_write_data[i][RW-1:1]);
      if (frq_write_data[i][0]) begin
        chk("wdata", fout_write_data[i], ref_pat(a, p, run_mode));
        mem[i][a] = fout_write_data[i];
        if (fault[i] == 1 && a == 1) mem[i][a] = mem[i][a] | 32'h8;
      end else begin
        rq_data[i][tail[i] % 64] = (fault[i] == 2) ? '0 : mem[i][a];
        rq_rdy[i][tail[i] % 64] = cyc + delay[i];
        tail[i]++;
        outst[i]++;
        chk("outstanding", 32'(outst[i] <= ((i == 0) ? 4 : 1)), 1);
      end
      k[i]++;
    end
  endtask

  initial begin : model
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      head[i] = 0; tail[i] = 0; k[i] = 0; pops[i] = 0; outst[i] = 0;
      frq_full[i] = 1'b0; fout_full[i] = 1'b0;
      fin_empty[i] = 1'b1; fin_read_data[i] = '0;
      for (int a = 0; a < N; a++) mem[i][a] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        case (full_mode[i])
          1: begin
            frq_full[i]  = (cyc % 2 == 1);
            fout_full[i] = (cyc % 2 == 1);
          end
          2: begin
            frq_full[i]  = ($urandom_range(0, 2) == 0);
            fout_full[i] = ($urandom_range(0, 2) == 0);
          end
          default: begin
            frq_full[i]  = 1'b0;
            fout_full[i] = 1'b0;
          end
        endcase
        if (head[i] != tail[i] && rq_rdy[i][head[i] % 64] <= cyc) begin
          fin_empty[i]     = 1'b0;
          fin_read_data[i] = rq_data[i][head[i] % 64];
        end else begin
          fin_empty[i]     = 1'b1;
          fin_read_data[i] = $urandom;
        end
      end
      #1;
      for (int i = 0; i < 2; i++) observe(i);
    end
  end

  task automatic chk_reset_vals();
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctrl", {26'd0, frq_write_en[i], fout_write_en[i],
          fin_read_en[i], busy[i], done[i], error[i]}, 0);
      chk("rst_req", 32'(frq_write_data[i]), 0);
      chk("rst_wdata", fout_write_data[i], 0);
      chk("rst_cnt", 32'(err_count[i]), 0);
      chk("rst_first", 32'(first_err_addr[i]), 0);
    end
  endtask

  task automatic kick(input int m, input int np);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; pops[i] = 0; last_pop[i] = -1; last_req[i] = 0;
    end
    run_mode    = m;
    total_reads = N * ((np == 0) ? 1 : np);
    mode   = 2'(m);
    passes = 4'(np);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mode   = 2'($urandom);
    passes = 4'($urandom);
    for (int i = 0; i < 2; i++) chk("busy_rise", 32'(busy[i]), 1);
  endtask

  task automatic run(input int m, input int np, input bit poke);
    int dc [2];
    int ce, fe, ee;
    kick(m, np);
    dc[0] = -1; dc[1] = -1;
    for (int t = 0; t < 3000 && (dc[0] < 0 || dc[1] < 0); t++) begin
      if (poke && t == 1 && busy[0] && busy[1]) begin
        start = 1'b1;
        mode  = 2'(m + 1);
      end
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++)
        if (dc[i] < 0 && done[i]) dc[i] = cyc;
    end
    for (int i = 0; i < 2; i++) begin
      exp_res(i, m, np, ce, fe, ee);
      chk("done", 32'(done[i]), 1);
      chk("busy_fall", 32'(busy[i]), 0);
      chk("done_cyc", dc[i], last_pop[i] + 1);
      chk("err_count", 32'(err_count[i]), ce);
      chk("error", 32'(error[i]), ee);
      chk("first_err_addr", 32'(first_err_addr[i]), fe);
    end
  endtask

  task automatic reset_mid_read();
    int t;
    kick(0, 2);
    t = 0;
    while (k[0] <= N && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("reached_read", 32'(k[0] > N && busy[0]), 1);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
  endtask

  task automatic cfg(input int f0, input int f1, input int d0, input int d1,
                     input int x0, input int x1);
    full_mode[0] = f0; full_mode[1] = f1;
    delay[0] = d0; delay[1] = d1;
    fault[0] = x0; fault[1] = x1;
  endtask

  initial begin : main
    rst = 1'b0; start = 1'b0; mode = '0; passes = '0;
    cfg(0, 0, 1, 1, 0, 0);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    run(0, 1, 0);
    cfg(0, 0, 1, 5, 1, 1);
    run(1, 2, 0);
    cfg(1, 0, 1, 5, 0, 0);
    run(2, 1, 0);
    cfg(1, 1, 2, 3, 0, 0);
    run(3, 2, 0);
    cfg(0, 0, 1, 1, 0, 2);
    run(3, 3, 0);
    cfg(0, 0, 1, 2, 0, 0);
    run(0, 2, 1);
    cfg(0, 2, 1, 5, 0, 0);
    reset_mid_read();
    run(1, 1, 0);

    repeat (12) begin
      cfg($urandom_range(0, 2), $urandom_range(0, 2),
          $urandom_range(1, 6), $urandom_range(1, 6),
          $urandom_range(0, 2), $urandom_range(0, 2));
      run($urandom_range(0, 3), $urandom_range(0, 4),
          1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
